// File: rtl/st_pkg.sv
// Shared symbol/beat geometry and packer state for the byte-to-RGB24 Avalon-ST packer.
// Also holds the small helpers that place symbols into a beat and compute the empty field.
package st_pkg;

  localparam int SYMBOL_W         = 8;
  localparam int SYMBOLS_PER_BEAT = 3;
  localparam int EMPTY_W          = 2;
  localparam int BEAT_W           = SYMBOL_W * SYMBOLS_PER_BEAT;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } packer_state_e;

  // Slot 0 is the most significant symbol, so the first byte lands in [23:16].
  function automatic logic [BEAT_W-1:0] place_symbol(
    input logic [BEAT_W-1:0]   beat,
    input logic [1:0]          slot,
    input logic [SYMBOL_W-1:0] sym
  );
    logic [BEAT_W-1:0] result;
    result = beat;
    case (slot)
      2'd0:    result[23:16] = sym;
      2'd1:    result[15:8]  = sym;
      2'd2:    result[7:0]   = sym;
      default: result        = beat;
    endcase
    return result;
  endfunction

  function automatic logic [EMPTY_W-1:0] empty_for(
    input logic [1:0] n_symbols,
    input logic       eop
  );
    logic [EMPTY_W-1:0] result;
    if (eop) begin
      result = 2'd3 - n_symbols;
    end else begin
      result = 2'd0;
    end
    return result;
  endfunction

endpackage

// File: rtl/st_out_reg_slice.sv
// Output holding register: captures one packed beat and holds it stable until downstream takes it.
// Sink side is ready whenever the register is empty or being emptied this cycle.
module st_out_reg_slice
  import st_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [BEAT_W-1:0]  load_data,
  input  logic               load_sop,
  input  logic               load_eop,
  input  logic [EMPTY_W-1:0] load_empty,
  output logic               load_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [BEAT_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty
);

  logic               valid_r;
  logic [BEAT_W-1:0]  data_r;
  logic               sop_r;
  logic               eop_r;
  logic [EMPTY_W-1:0] empty_r;
  logic               load_ready_s;

  assign load_ready_s      = !valid_r || out_ready;
  assign load_ready        = load_ready_s;
  assign out_valid         = valid_r;
  assign out_data          = data_r;
  assign out_startofpacket = sop_r;
  assign out_endofpacket   = eop_r;
  assign out_empty         = empty_r;

  // Load a new beat, retire a transferred one, or hold the stalled one.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= 24'h000000;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      empty_r <= 2'd0;
    end else if (load_valid && load_ready_s) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      sop_r   <= load_sop;
      eop_r   <= load_eop;
      empty_r <= load_empty;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/st_byte_to_rgb24_packer.sv
// Packs an 8-bit Avalon-ST packet stream into 24-bit beats with sop/eop/empty,
// dropping orphan bytes, restarting on premature sop and counting framing errors.
module st_byte_to_rgb24_packer
  import st_pkg::*;
#(
  parameter int ERR_CNT_W    = 16,
  parameter bit DROP_ORPHANS = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [SYMBOL_W-1:0]  in_data,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [BEAT_W-1:0]    out_data,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_pulse
);

  packer_state_e          state_r;
  logic [1:0]             count_r;
  logic                   sop_pending_r;
  logic [BEAT_W-1:0]      buf_r;
  logic [ERR_CNT_W-1:0]   err_count_r;
  logic                   err_pulse_r;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   start_s;
  logic                   err_s;
  logic                   take_s;
  logic                   emit_s;
  logic [BEAT_W-1:0]      base_buf_s;
  logic [1:0]             base_cnt_s;
  logic [BEAT_W-1:0]      packed_s;
  logic [1:0]             fill_s;
  logic                   beat_sop_s;
  logic [EMPTY_W-1:0]     beat_empty_s;

  assign in_ready  = in_ready_s;
  assign accept_s  = in_valid && in_ready_s;
  assign err_count = err_count_r;
  assign err_pulse = err_pulse_r;

  // Classify the accepted byte: new packet start, continuation, or framing error.
  always_comb begin
    start_s = 1'b0;
    err_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (in_startofpacket || (DROP_ORPHANS == 1'b0)) begin
            start_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        PKT: begin
          if (in_startofpacket) begin
            start_s = 1'b1;
            err_s   = 1'b1;
          end else begin
            start_s = 1'b0;
          end
        end
        default: begin
          start_s = 1'b0;
          err_s   = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
      err_s   = 1'b0;
    end
  end

  // A restart throws away the partial beat, so packing begins from an empty buffer.
  always_comb begin
    take_s     = accept_s && (start_s || (state_r == PKT));
    base_buf_s = buf_r;
    base_cnt_s = count_r;
    if (start_s) begin
      base_buf_s = 24'h000000;
      base_cnt_s = 2'd0;
    end else begin
      base_buf_s = buf_r;
      base_cnt_s = count_r;
    end
    packed_s     = place_symbol(base_buf_s, base_cnt_s, in_data);
    fill_s       = base_cnt_s + 2'd1;
    emit_s       = take_s && ((fill_s == 2'd3) || in_endofpacket);
    beat_sop_s   = start_s || sop_pending_r;
    beat_empty_s = empty_for(fill_s, in_endofpacket);
  end

  // Packing state: symbol buffer, fill count, pending sop and packet state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      count_r       <= 2'd0;
      sop_pending_r <= 1'b0;
      buf_r         <= 24'h000000;
    end else if (take_s) begin
      if (emit_s) begin
        buf_r         <= 24'h000000;
        count_r       <= 2'd0;
        sop_pending_r <= 1'b0;
        state_r       <= in_endofpacket ? IDLE : PKT;
      end else begin
        buf_r         <= packed_s;
        count_r       <= fill_s;
        sop_pending_r <= beat_sop_s;
        state_r       <= PKT;
      end
    end else begin
      state_r       <= state_r;
      count_r       <= count_r;
      sop_pending_r <= sop_pending_r;
      buf_r         <= buf_r;
    end
  end

  // Saturating framing-error counter and its one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r <= '0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= err_s;
      if (err_s && (err_count_r != {ERR_CNT_W{1'b1}})) begin
        err_count_r <= err_count_r + ERR_CNT_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  st_out_reg_slice u_out_slice (
    .clk               (clk),
    .reset             (reset),
    .load_valid        (emit_s),
    .load_data         (packed_s),
    .load_sop          (beat_sop_s),
    .load_eop          (in_endofpacket),
    .load_empty        (beat_empty_s),
    .load_ready        (in_ready_s),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty)
  );

endmodule

// File: tb/tb_st_byte_to_rgb24_packer.sv
// Bench for st_byte_to_rgb24_packer: directed framing cases plus random traffic,
// scored against a packet-level reference model built from byte lists.
module tb_st_byte_to_rgb24_packer;

  localparam int ECW     = 3;
  localparam int ERR_MAX = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_ready;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_startofpacket = 1'b0;
  logic        in_endofpacket = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic [ECW-1:0] err_count;
  logic        err_pulse;

  st_byte_to_rgb24_packer #(.ERR_CNT_W(ECW), .DROP_ORPHANS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .err_count(err_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; bit sop; bit eop; } sym_t;
  typedef logic [7:0] byte_q_t[$];
  typedef logic [27:0] beat_t; // {sop, eop, empty[1:0], data[23:0]}

  sym_t  stim_q[$];
  beat_t exp_q[$];
  beat_t seen_q[$];
  logic [7:0] cur_q[$];
  bit    active, first_beat;
  int    errs;
  bit    exp_pulse;
  int    pulse_cnt;
  int    ready_mode;   // 0 random, 1 always ready, 2 never ready
  bit    rand_valid;
  bit    prev_stalled;
  beat_t prev_beat;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_errs(input int e);
    return (e > ERR_MAX) ? ERR_MAX : e;
  endfunction

  function automatic beat_t cur_beat();
    return {out_startofpacket, out_endofpacket, out_empty, out_data};
  endfunction

  // Reference: collect bytes of the current packet and cut a beat every 3 bytes or at eop.
  task automatic model_accept(input sym_t s, output bit err);
    logic [23:0] d;
    int n;
    err = 1'b0;
    if (s.sop) begin
      if (active) err = 1'b1;
      cur_q.delete();
      active = 1'b1;
      first_beat = 1'b1;
    end else if (!active) begin
      err = 1'b1;
      return;
    end
    cur_q.push_back(s.d);
    n = cur_q.size();
    if (n == 3 || s.eop) begin
      d = 24'h0;
      for (int i = 0; i < n; i++) d = d | (24'(cur_q[i]) << (16 - 8 * i));
      exp_q.push_back({first_beat, s.eop, (s.eop ? 2'(3 - n) : 2'd0), d});
      first_beat = 1'b0;
      cur_q.delete();
      if (s.eop) active = 1'b0;
    end
  endtask

  task automatic push_pkt(input byte_q_t b);
    for (int i = 0; i < b.size(); i++) begin
      sym_t s;
      s.d = b[i];
      s.sop = (i == 0);
      s.eop = (i == b.size() - 1);
      stim_q.push_back(s);
    end
  endtask

  task automatic push_sym(input logic [7:0] d, input bit sop, input bit eop);
    sym_t s;
    s.d = d; s.sop = sop; s.eop = eop;
    stim_q.push_back(s);
  endtask

  // One clock: check what the last edge produced, then drive and predict the next edge.
  task automatic cycle();
    bit e;
    sym_t s;
    @(negedge clk);
    check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_val("err_pulse", 32'(err_pulse), 32'(exp_pulse));
    check_val("err_count", 32'(err_count), 32'(sat_errs(errs)));
    if (err_pulse) pulse_cnt++;
    if (prev_stalled) check_val("hold_stable", 32'(cur_beat()), 32'(prev_beat));
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 2) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
    if (stim_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      in_data = stim_q[0].d;
      in_startofpacket = stim_q[0].sop;
      in_endofpacket = stim_q[0].eop;
    end else begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      in_startofpacket = 1'($urandom);
      in_endofpacket = 1'($urandom);
    end
    #1;
    check_val("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat", 32'(cur_beat()), 32'hFFFFFFFF);
      end else begin
        check_val("beat", 32'(cur_beat()), 32'(exp_q.pop_front()));
      end
      seen_q.push_back(cur_beat());
    end
    exp_pulse = 1'b0;
    if (in_valid && in_ready) begin
      s = stim_q.pop_front();
      model_accept(s, e);
      if (e) errs++;
      exp_pulse = e;
    end
    prev_stalled = out_valid && !out_ready;
    prev_beat = cur_beat();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      cycle();
      n++;
    end
    check_val("drain_timeout", 32'(n >= 5000), 32'd0);
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stim_q.delete(); exp_q.delete(); cur_q.delete();
    active = 1'b0; first_beat = 1'b0; errs = 0; exp_pulse = 1'b0; prev_stalled = 1'b0;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    check_val("rst_err_pulse", 32'(err_pulse), 32'd0);
  endtask

  task automatic check_seen(input string tag, input beat_t exp[$]);
    check_val({tag, "_nbeats"}, 32'(seen_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen_q.size(); i++)
      check_val(tag, 32'(seen_q[i]), 32'(exp[i]));
    seen_q.delete();
  endtask

  initial begin
    int n;
    active = 1'b0; first_beat = 1'b0; errs = 0; exp_pulse = 1'b0;
    pulse_cnt = 0; ready_mode = 1; rand_valid = 1'b0; prev_stalled = 1'b0;

    repeat (2) @(negedge clk);
    do_reset();
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_flags", 32'({out_startofpacket, out_endofpacket, out_empty}), 32'd0);

    push_pkt('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    drain();
    check_seen("six_byte", '{{1'b1, 1'b0, 2'd0, 24'h112233}, {1'b0, 1'b1, 2'd0, 24'h445566}});

    push_pkt('{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    push_pkt('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    drain();
    check_seen("short_tail", '{{1'b1, 1'b0, 2'd0, 24'hAABBCC}, {1'b0, 1'b1, 2'd2, 24'hDD0000},
                               {1'b1, 1'b0, 2'd0, 24'h010203}, {1'b0, 1'b1, 2'd1, 24'h040500}});

    push_pkt('{8'h5A});
    drain();
    check_seen("single", '{{1'b1, 1'b1, 2'd2, 24'h5A0000}});

    // Stall downstream for 10 cycles after the first beat while bytes keep coming.
    push_pkt('{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA, 8'hCB});
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    check_val("stall_first_beat", 32'(out_valid), 32'd1);
    ready_mode = 2;
    repeat (10) cycle();
    ready_mode = 1;
    drain();
    check_seen("stall", '{{1'b1, 1'b0, 2'd0, 24'hC0C1C2}, {1'b0, 1'b0, 2'd0, 24'hC3C4C5},
                          {1'b0, 1'b0, 2'd0, 24'hC6C7C8}, {1'b0, 1'b1, 2'd0, 24'hC9CACB}});

    pulse_cnt = 0;
    push_sym(8'h99, 1'b0, 1'b0);
    drain();
    check_val("orphan_cnt", 32'(err_count), 32'd1);
    check_val("orphan_pulses", 32'(pulse_cnt), 32'd1);
    check_seen("orphan", '{});

    push_sym(8'h01, 1'b1, 1'b0);
    push_sym(8'h02, 1'b0, 1'b0);
    push_pkt('{8'h10, 8'h20, 8'h30, 8'h40});
    drain();
    check_val("premature_cnt", 32'(err_count), 32'd2);
    check_seen("premature", '{{1'b1, 1'b0, 2'd0, 24'h102030}, {1'b0, 1'b1, 2'd2, 24'h400000}});

    push_sym(8'h77, 1'b1, 1'b0);
    drain();
    do_reset();
    push_pkt('{8'hE1, 8'hE2, 8'hE3, 8'hE4});
    drain();
    check_seen("after_rst1", '{{1'b1, 1'b0, 2'd0, 24'hE1E2E3}, {1'b0, 1'b1, 2'd2, 24'hE40000}});

    ready_mode = 2;
    push_pkt('{8'h31, 8'h32, 8'h33, 8'h34});
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    repeat (2) cycle();
    check_val("stale_held", 32'(out_valid), 32'd1);
    do_reset();
    ready_mode = 1;
    push_pkt('{8'h41, 8'h42, 8'h43});
    drain();
    check_seen("after_rst2", '{{1'b1, 1'b1, 2'd0, 24'h414243}});

    // Random traffic, including orphans and premature sops, enough to saturate err_count.
    ready_mode = 0;
    rand_valid = 1'b1;
    for (int p = 0; p < 250; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        bit cut;
        cut = (i == len - 1) && ($urandom_range(0, 9) == 0);
        push_sym(8'($urandom), (i == 0) ? ($urandom_range(0, 14) != 0) : 1'b0,
                 (i == len - 1) && !cut);
      end
    end
    drain();
    check_val("sat_count", 32'(err_count), 32'(sat_errs(errs)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/st_byte_to_rgb24_packer.md
Name: st_byte_to_rgb24_packer

Overview:
- Upstream neighbour of the 24-bit output format adapter.
- Packs an 8-bit Avalon-ST packet stream (one symbol per beat) into 24-bit beats (3 symbols per beat) with sop/eop/empty.
- Feeds the adapter's in_* interface directly.
- Detects malformed framing (orphan bytes, premature sop) and counts the errors.

Parameters:
- ERR_CNT_W, 16, width of the saturating framing-error counter.
- DROP_ORPHANS, 1. 1: bytes arriving outside a packet without sop are dropped and counted. 0: such a byte is treated as an implicit sop.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  sink ready
- in_valid  in  1  byte valid
- in_data  in  8  symbol
- in_startofpacket  in  1  first byte of packet
- in_endofpacket  in  1  last byte of packet
- out_ready  in  1  downstream ready
- out_valid  out  1  beat valid
- out_data  out  24  packed beat
- out_startofpacket  out  1  first beat of packet
- out_endofpacket  out  1  last beat of packet
- out_empty  out  2  unused symbols in final beat (0..2)
- err_count  out  ERR_CNT_W  saturating count of framing errors
- err_pulse  out  1  one-cycle pulse per framing error

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. All state changes on rising clk.
- Reset values:
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0.
  - err_count=0, err_pulse=0.
  - State=IDLE, symbol count=0, sop_pending=0.
  - Reset mid-packet discards the partial beat and any held output beat, with no eop emitted.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, registered-output style, so no combinational path from in_valid.
  - Output beat presented on registered out_* and held stable while out_valid && !out_ready.
  - Transfer when out_valid && out_ready.
- Packing order: first symbol goes to out_data[23:16], second to [15:8], third to [7:0]. Unused low symbols are zero-filled.
- State machine:
  - IDLE, accepted byte with sop: load symbol slot 0, count=1, sop_pending=1, go to PKT.
  - IDLE, accepted byte without sop:
    - DROP_ORPHANS=1: drop the byte and flag an error.
    - DROP_ORPHANS=0: treat as sop.
  - PKT, accepted byte without sop: write slot[count], count++.
  - PKT, accepted byte with sop (premature sop): discard the partial beat, flag an error, restart as IDLE+sop in the same cycle.
- Beat emission: occurs on the byte that makes count reach 3, or on a byte carrying eop.
  - Register out_data and out_valid=1.
  - out_startofpacket=sop_pending, then clear sop_pending.
  - out_endofpacket=eop.
  - out_empty = 3 - symbols in beat, forced to 0 when eop=0.
  - count returns to 0. On eop, state returns to IDLE.
- Latency: one cycle from the completing input byte to out_valid.
- Throughput: 1 byte/cycle sustained; output is at most 1 beat per 3 cycles except for short packets.
- Single-byte packet (sop&eop together): beat = {b,0x00,0x00}, empty=2, sop=1, eop=1.
- Backpressure: in_ready is low while a held beat is stalled, even for non-completing bytes. No byte is ever lost or duplicated.
- Error counter:
  - Increments by 1 per error and saturates at all-ones.
  - err_pulse is high for the cycle after the erroring accept.
  - An error and a beat emission in the same cycle are both honoured.

Decomposition:
- Shared package st_pkg:
  - SYMBOL_W=8, SYMBOLS_PER_BEAT=3, EMPTY_W=2.
  - Packer state enum {IDLE, PKT}.
- One natural sub-module: st_out_reg_slice, the output holding register that implements the valid/ready hold rule. The packing FSM lives in the top.

Test Plan:
- Packet 0x11,0x22,0x33,0x44,0x55,0x66 (sop on first, eop on last), out_ready=1 -> beats 0x112233 sop=1 eop=0 empty=0; 0x445566 sop=0 eop=1 empty=0.
- Packet 0xAA,0xBB,0xCC,0xDD with eop on 0xDD -> 0xAABBCC sop=1; 0xDD0000 eop=1 empty=2. A 5-byte packet gives a final beat with empty=1.
- Single byte 0x5A with sop&eop -> 0x5A0000, sop=1, eop=1, empty=2, one cycle after accept.
- out_ready held low 10 cycles after first beat while bytes offered -> out_data stable, in_ready=0, no drops. After release, the byte sequence is intact.
- Orphan 0x99 in IDLE with DROP_ORPHANS=1 -> no output, err_count 0->1, one err_pulse. Premature sop after 2 bytes -> partial discarded, err_count=2, new packet packs correctly.
- Assert reset mid-packet after 1 byte and with a stalled beat -> out_valid=0, count cleared. The next sop packet produces correct beats, and the stale beat never appears.
